fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 keep  input  1  hold IF/ID outputs and PC, same stall as the decode stage.
REQ-006 nop  input  1  flush: IF/ID loads a bubble next edge.
REQ-007 branch_PC_early_contral  input  1  early-branch redirect from decode.
REQ-008 branch_PC_early  input  32  early-branch target.
REQ-009 branch_PC_late_contral  input  1  late redirect from EX/MEM (jalr, blt/bge family).
REQ-010 branch_PC_late  input  32  late redirect target.
REQ-011 imem_req  output  1  fetch request valid.
REQ-012 imem_addr  output  32  fetch address, word aligned.
REQ-013 imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-014 imem_rvalid  input  1  response valid; in order, at least 1 cycle after acceptance.
REQ-015 imem_rdata  input  32  response instruction.
REQ-016 PC_pype0  output  32  PC of Instraction_pype.
REQ-017 PCp4_pype0  output  32  PC_pype0 + 4.
REQ-018 Instraction_pype  output  32  instruction presented to decode.

Function
REQ-019 SHALL allow at most one outstanding imem request.
REQ-020 FSM states: IDLE (after reset, 1 cycle), REQ (imem_req high), WAIT (one request outstanding), WAIT_KILL (outstanding response to be discarded).
REQ-021 Transitions: IDLE->REQ; REQ->WAIT on grant; WAIT->REQ on rvalid if buffer has space, otherwise WAIT->HOLD-in-REQ with imem_req low; WAIT->WAIT_KILL on redirect; WAIT_KILL->REQ on rvalid with data dropped.
REQ-022 Fetch PC SHALL increment by 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0) on each grant.
REQ-023 Redirect priority: late > early > sequential; redirect reloads fetch PC, clears the instruction buffer, and drops any ungranted request the same cycle.
REQ-024 Redirect SHALL also load IF/ID with NOP_INST, PC 0, PCp4 0 at the next edge, regardless of keep.
REQ-025 imem_addr SHALL equal the redirect target in the cycle after a redirect when no request is outstanding.
REQ-026 Response with an empty buffer and keep=0 SHALL bypass to IF/ID at the edge ending the rvalid cycle (grant cycle N -> Instraction_pype valid from N+2 at minimum).
REQ-027 keep=1 and no redirect: IF/ID, PC_pype0, PCp4_pype0 held; responses are written to the buffer.
REQ-028 nop=1 and no redirect: IF/ID loads a bubble; the buffer is not popped; nop has priority over keep.
REQ-029 keep=0 with an empty buffer and no response: IF/ID loads a bubble (no stale instruction is repeated).
REQ-030 A request SHALL only be issued when buffer free slots exceed outstanding count.
REQ-031 imem_addr bits [1:0] SHALL always be 2'b00; target bits [1:0] are ignored.

Reset
REQ-032 rst low: FSM=IDLE, fetch PC=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, Instraction_pype=NOP_INST, PC_pype0=0, PCp4_pype0=0.
REQ-033 Reset asserted with a request outstanding: the late response after release SHALL be discarded (enter WAIT_KILL-equivalent via a response-ignore flag until the first rvalid or first grant).

Configuration
REQ-034 Macro FETCH_SKID_BUF_EN defined: instruction buffer is a 2-entry FIFO (PC+instruction), allowing one fetch in flight while one instruction waits behind a keep.
REQ-035 Macro undefined: the buffer is 1 entry; with it full, imem_req stays low; all other behaviour is identical.

Verification
REQ-036 Reset release, gnt=1, 1-cycle rvalid, rdata=32'h0010_0093 -> imem_addr 0,4,8; Instraction_pype=32'h0010_0093, PC_pype0=0, PCp4_pype0=4 at cycle 3.
REQ-037 keep high 3 cycles mid-stream -> IF/ID unchanged; with FETCH_SKID_BUF_EN at most 2 responses buffered, then imem_req low; on release, instructions appear in order with no loss or duplication.
REQ-038 Early redirect to 32'h0000_0200 with a request outstanding -> outstanding response discarded, IF/ID=NOP_INST next edge, next granted imem_addr=32'h0000_0200.
REQ-039 Late and early redirect in the same cycle (0x300, 0x400) -> fetch resumes at 32'h0000_0300.
REQ-040 nop and keep together -> bubble loaded and buffer contents retained; RESET_PC=32'hFFFF_FFFC -> second imem_addr is 0.
REQ-041 rst asserted while waiting, rvalid arrives after release -> data dropped; first Instraction_pype comes from RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch with an in-order, single-outstanding
// instruction-memory port and an IF/ID register feeding decode.
//
// Configuration macro: FETCH_SKID_BUF_EN
//   defined   : 2-entry instruction buffer (one fetch can be in flight while
//               one instruction waits behind a decode stall)
//   undefined : 1-entry instruction buffer
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   keep                      decode stall: hold IF/ID and keep buffering
//   nop                       load a bubble into IF/ID (buffer not popped)
//   branch_PC_early_contral/  early redirect from decode and its target
//   branch_PC_early
//   branch_PC_late_contral/   late redirect from EX/MEM and its target
//   branch_PC_late            (late wins over early)
//   imem_req/imem_addr/       fetch request, accepted on req && gnt
//   imem_gnt
//   imem_rvalid/imem_rdata    in-order response, >= 1 cycle after grant
//   PC_pype0/PCp4_pype0/      IF/ID register: PC, PC+4 and instruction
//   Instraction_pype
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        nop,
  input  logic        branch_PC_early_contral,
  input  logic [31:0] branch_PC_early,
  input  logic        branch_PC_late_contral,
  input  logic [31:0] branch_PC_late,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WAIT_KILL} state_t;

`ifdef FETCH_SKID_BUF_EN
  localparam logic [1:0] BUF_DEPTH = 2'd2;
`else
  localparam logic [1:0] BUF_DEPTH = 2'd1;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        ign_q, ign_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] buf_pc_q   [2];
  logic [31:0] buf_pc_d   [2];
  logic [31:0] buf_inst_q [2];
  logic [31:0] buf_inst_d [2];
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;

  logic        redirect;
  logic [31:0] target;
  logic        has_space;
  logic        grant;
  logic        resp;
  logic        pop;
  logic        push;
  logic [1:0]  fill;

  assign redirect  = branch_PC_late_contral || branch_PC_early_contral;
  assign target    = (branch_PC_late_contral ? branch_PC_late : branch_PC_early)
                     & 32'hFFFF_FFFC;
  // Only REQ has no request outstanding, so one free slot is enough to
  // guarantee room for the response.
  assign has_space = cnt_q < BUF_DEPTH;
  // A redirect kills a not-yet-granted request in the same cycle.
  assign imem_req  = (state_q == S_REQ) && has_space && !redirect;
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  // Usable response: the one we are waiting for, not killed, not a leftover
  // from before reset, and not overtaken by a redirect this cycle.
  assign resp      = imem_rvalid && (state_q == S_WAIT) && !ign_q && !redirect;

  assign PC_pype0         = ifid_pc_q;
  assign PCp4_pype0       = ifid_pcp4_q;
  assign Instraction_pype = ifid_inst_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_REQ;
      S_REQ:       if (grant) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)   state_d = S_REQ;
        else if (redirect) state_d = S_WAIT_KILL;
      end
      S_WAIT_KILL: if (imem_rvalid) state_d = S_REQ;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    ign_d    = ign_q;
    if (redirect)   pc_d = target;
    else if (grant) pc_d = pc_q + 32'd4;
    if (grant) req_pc_d = pc_q;
    // After reset a response for a pre-reset request may still arrive; the
    // flag stays up until that response or our own first grant.
    if (imem_rvalid || grant) ign_d = 1'b0;
  end

  // IF/ID selection and instruction-buffer bookkeeping.
  always_comb begin
    ifid_inst_d = ifid_inst_q;
    ifid_pc_d   = ifid_pc_q;
    ifid_pcp4_d = ifid_pcp4_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    push        = resp;
    fill        = cnt_q;
    if (redirect) begin
      ifid_inst_d = NOP_INST;
      ifid_pc_d   = 32'd0;
      ifid_pcp4_d = 32'd0;
      cnt_d       = 2'd0;
      push        = 1'b0;
    end else begin
      if (nop) begin
        ifid_inst_d = NOP_INST;
        ifid_pc_d   = 32'd0;
        ifid_pcp4_d = 32'd0;
      end else if (keep) begin
        ifid_inst_d = ifid_inst_q;
      end else if (cnt_q != 2'd0) begin
        ifid_inst_d = buf_inst_q[0];
        ifid_pc_d   = buf_pc_q[0];
        ifid_pcp4_d = buf_pc_q[0] + 32'd4;
        pop         = 1'b1;
      end else if (resp) begin
        // Empty buffer: the response goes straight to decode.
        ifid_inst_d = imem_rdata;
        ifid_pc_d   = req_pc_q;
        ifid_pcp4_d = req_pc_q + 32'd4;
        push        = 1'b0;
      end else begin
        // Nothing to hand over: never repeat the previous instruction.
        ifid_inst_d = NOP_INST;
        ifid_pc_d   = 32'd0;
        ifid_pcp4_d = 32'd0;
      end
      // Head is always entry 0; a pop shifts entry 1 down.
      if (pop) begin
        buf_pc_d[0]   = buf_pc_q[1];
        buf_inst_d[0] = buf_inst_q[1];
        fill          = cnt_q - 2'd1;
      end
      if (push) begin
        if (fill == 2'd0) begin
          buf_pc_d[0]   = req_pc_q;
          buf_inst_d[0] = imem_rdata;
        end else begin
          buf_pc_d[1]   = req_pc_q;
          buf_inst_d[1] = imem_rdata;
        end
        fill = fill + 2'd1;
      end
      cnt_d = fill;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC & 32'hFFFF_FFFC;
      ign_q       <= 1'b1;
      cnt_q       <= 2'd0;
      ifid_inst_q <= NOP_INST;
      ifid_pc_q   <= 32'd0;
      ifid_pcp4_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ign_q       <= ign_d;
      cnt_q       <= cnt_d;
      ifid_inst_q <= ifid_inst_d;
      ifid_pc_q   <= ifid_pc_d;
      ifid_pcp4_q <= ifid_pcp4_d;
    end
  end

  // Payload storage; validity is carried by state_q / cnt_q.
  always_ff @(posedge clk) begin
    req_pc_q   <= req_pc_d;
    buf_pc_q   <= buf_pc_d;
    buf_inst_q <= buf_inst_d;
  end

endmodule
